mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL: W_clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: W_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: W_valid  in  1  EX-stage result valid this cycle.
REQ-004 SHALL: W_alu_res  in  INSTR_WIDTH(32)  ALU result; effective address for loads/stores, writeback data otherwise.
REQ-005 SHALL: W_wdata  in  32  store data (rt value).
REQ-006 SHALL: W_mem_op  in  4  MEM_NONE, MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU, MEM_SW, MEM_SH, MEM_SB.
REQ-007 SHALL: W_wb_reg  in  5  destination register; W_wb_en  in  1  register write enable.
REQ-008 SHALL: R_dreq  out  1  data-bus request; R_dwe  out  1  write strobe; R_daddr  out  32  word-aligned address ({addr[31:2],2'b00}); R_dbe  out  4  byte enables; R_dwdata  out  32  store data.
REQ-009 SHALL: W_dack  in  1  data-bus acknowledge; W_drdata  in  32  read data, valid in the W_dack cycle.
REQ-010 SHALL: R_wb_valid  out  1; R_wb_data  out  32; R_wb_reg  out  5; R_wb_en  out  1  registered result to WB.
REQ-011 SHALL: R_stall  out  1  upstream must hold its inputs while high.
REQ-012 SHALL: R_addr_err  out  1  misaligned-access pulse; R_bad_addr  out  32  offending address.

Function
REQ-013 SHALL: FSM states IDLE, BUSY; an input is accepted only when W_valid=1 and state=IDLE; inputs presented in BUSY are ignored.
REQ-014 SHALL: MEM_NONE accepted -> next cycle R_wb_valid=1, R_wb_data=W_alu_res, R_wb_reg/R_wb_en copied; state stays IDLE (latency 1).
REQ-015 SHALL: aligned load/store accepted -> next cycle state=BUSY, R_dreq=1, with R_daddr/R_dbe/R_dwe/R_dwdata held stable until the ack.
REQ-016 SHALL: R_stall=1 exactly while state=BUSY.
REQ-017 SHALL: W_dack=1 in BUSY -> next cycle R_dreq=0, state=IDLE, R_wb_valid=1 (1-cycle pulse); stores force R_wb_en=0; R_wb_data is don't-care for stores. Ack in the first BUSY cycle is legal. The minimum load/store latency is 2 cycles.
REQ-018 SHALL: W_dack while IDLE is ignored.
REQ-019 SHALL: byte enables (little-endian): SW 4'b1111; SH addr[1]?4'b1100:4'b0011; SB 4'b0001<<addr[1:0]; loads read with R_dbe=4'b1111.
REQ-020 SHALL: store data replicated across lanes: SH {2{wdata[15:0]}}, SB {4{wdata[7:0]}}, SW wdata.
REQ-021 SHALL: load data selected by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW unmodified.
REQ-022 SHALL: misaligned access (LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0) -> no bus request, next cycle R_addr_err=1 for one cycle, R_bad_addr=W_alu_res, R_wb_valid=0, state stays IDLE.
REQ-023 SHALL: R_wb_valid=0 in every cycle without a completing result; outputs otherwise hold their last value.

Reset
REQ-024 SHALL: W_rst=1 at an edge -> state=IDLE; R_dreq, R_dwe, R_wb_valid, R_wb_en, R_stall, R_addr_err=0; all data/address outputs=0.
REQ-025 SHALL: reset during BUSY abandons the transfer; a W_dack in or after the reset cycle produces no writeback.

Structure
REQ-026 SHALL: the MEM_* op encodings and INSTR_WIDTH live in the shared defines file next to the ALU_* codes.
REQ-027 SHALL: combinational lane select and extension for loads is the sub-module load_align (inputs op, addr[1:0], rdata; output 32-bit result).

Verification
REQ-028 SHALL: MEM_NONE, alu_res=32'h0000_1234, wb_reg=5 -> next cycle wb_valid=1, wb_data=32'h0000_1234, wb_reg=5, no dreq.
REQ-029 SHALL: LB at 32'h0000_1003, ack after 3 cycles with rdata=32'h80FF_0000 -> dreq held 3 cycles, daddr=32'h0000_1000, stall high throughout, wb_data=32'hFFFF_FF80; LBU -> 32'h0000_0080.
REQ-030 SHALL: SH at 32'h0000_2002, wdata=32'hDEAD_BEEF -> dwe=1, dbe=4'b1100, dwdata=32'hBEEF_BEEF, wb_en=0 on completion.
REQ-031 SHALL: LW at 32'h0000_0006 -> no dreq, addr_err pulse 1 cycle, bad_addr=32'h0000_0006, wb_valid=0.
REQ-032 SHALL: SW issued, W_rst asserted in the second BUSY cycle, ack the cycle after -> all outputs 0, no wb_valid.
REQ-033 SHALL: ack in the same cycle dreq first rises, back-to-back LW/LW -> each completes in 2 cycles, second accepted only after IDLE.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared pipeline defines for the MEM stage. Holds the
//               datapath width, the ALU opcode set, the MEM_* operation
//               encodings, the MEM-stage FSM state type, and helper
//               functions for op classification, byte-lane enables and
//               store-data replication.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  localparam int INSTR_WIDTH = 32;

  // ALU operation codes used by the EX stage
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // MEM-stage operation codes
  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LW   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LHU  = 4'd3;
  localparam logic [3:0] MEM_LB   = 4'd4;
  localparam logic [3:0] MEM_LBU  = 4'd5;
  localparam logic [3:0] MEM_SW   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SB   = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LW) || (op == MEM_LH) || (op == MEM_LHU) ||
           (op == MEM_LB) || (op == MEM_LBU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
  endfunction

  // Word ops need a 4-byte aligned address, halfword ops 2-byte aligned.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    if ((op == MEM_LW) || (op == MEM_SW))
      r = (lo != 2'b00);
    else if ((op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH))
      r = lo[0];
    return r;
  endfunction

  // Little-endian lane enables; loads always read the whole word.
  function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] lo);
    logic [3:0] r;
    case (op)
      MEM_SH:  r = lo[1] ? 4'b1100 : 4'b0011;
      MEM_SB:  r = 4'b0001 << lo;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Narrow stores are replicated so the enabled lane always carries the data.
  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wd);
    logic [31:0] r;
    case (op)
      MEM_SH:  r = {2{wd[15:0]}};
      MEM_SB:  r = {4{wd[7:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational lane select and extension of load data.
// Ports       : op     in  4   MEM_* load operation
//               addr   in  2   byte offset within the word
//               rdata  in  32  raw word from the data bus
//               result out 32  aligned, sign/zero-extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[{addr, 3'b000} +: 8];
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_LB:  result = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: result = {24'h000000, w_byte};
      MEM_LH:  result = {{16{w_half[15]}}, w_half};
      MEM_LHU: result = {16'h0000, w_half};
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Pipeline MEM stage. Passes non-memory results straight to
//               writeback, runs loads/stores over a request/acknowledge data
//               bus with stall, and flags misaligned accesses.
// Ports       : W_clk, W_rst                 clock, sync active-high reset
//               W_valid/W_alu_res/W_wdata/
//               W_mem_op/W_wb_reg/W_wb_en     EX-stage result
//               R_dreq/R_dwe/R_daddr/R_dbe/
//               R_dwdata, W_dack/W_drdata     data bus
//               R_wb_valid/R_wb_data/
//               R_wb_reg/R_wb_en              registered result to WB
//               R_stall                       upstream hold
//               R_addr_err/R_bad_addr         misaligned-access report
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
  import mem_access_pkg::*;
(
  input  logic                   W_clk,
  input  logic                   W_rst,
  input  logic                   W_valid,
  input  logic [INSTR_WIDTH-1:0] W_alu_res,
  input  logic [31:0]            W_wdata,
  input  logic [3:0]             W_mem_op,
  input  logic [4:0]             W_wb_reg,
  input  logic                   W_wb_en,
  output logic                   R_dreq,
  output logic                   R_dwe,
  output logic [31:0]            R_daddr,
  output logic [3:0]             R_dbe,
  output logic [31:0]            R_dwdata,
  input  logic                   W_dack,
  input  logic [31:0]            W_drdata,
  output logic                   R_wb_valid,
  output logic [31:0]            R_wb_data,
  output logic [4:0]             R_wb_reg,
  output logic                   R_wb_en,
  output logic                   R_stall,
  output logic                   R_addr_err,
  output logic [31:0]            R_bad_addr
);

  state_t      r_state;
  state_t      w_state_next;

  // Context of the in-flight transfer, needed when the ack arrives
  logic [3:0]  r_op;
  logic [1:0]  r_addr_lo;
  logic [4:0]  r_pend_reg;
  logic        r_pend_en;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_done;
  logic [31:0] w_load_data;

  assign w_accept   = W_valid && (r_state == ST_IDLE);
  assign w_is_mem   = is_load(W_mem_op) || is_store(W_mem_op);
  assign w_misalign = is_misaligned(W_mem_op, W_alu_res[1:0]);
  assign w_done     = (r_state == ST_BUSY) && W_dack;

  assign R_stall    = (r_state == ST_BUSY);

  load_align u_load_align (
    .op     (r_op),
    .addr   (r_addr_lo),
    .rdata  (W_drdata),
    .result (w_load_data)
  );

  always_ff @(posedge W_clk) begin
    if (W_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_mem && !w_misalign) w_state_next = ST_BUSY;
      ST_BUSY: if (W_dack)                               w_state_next = ST_IDLE;
      default:                                           w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge W_clk) begin
    if (W_rst) begin
      R_dreq     <= 1'b0;
      R_dwe      <= 1'b0;
      R_daddr    <= 32'h0;
      R_dbe      <= 4'h0;
      R_dwdata   <= 32'h0;
      R_wb_valid <= 1'b0;
      R_wb_data  <= 32'h0;
      R_wb_reg   <= 5'h0;
      R_wb_en    <= 1'b0;
      R_addr_err <= 1'b0;
      R_bad_addr <= 32'h0;
      r_op       <= MEM_NONE;
      r_addr_lo  <= 2'b00;
      r_pend_reg <= 5'h0;
      r_pend_en  <= 1'b0;
    end else begin
      // Pulses; every other output holds unless updated below.
      R_wb_valid <= 1'b0;
      R_addr_err <= 1'b0;

      if (w_accept) begin
        if (!w_is_mem) begin
          // Unrecognised op codes are treated as MEM_NONE.
          R_wb_valid <= 1'b1;
          R_wb_data  <= W_alu_res;
          R_wb_reg   <= W_wb_reg;
          R_wb_en    <= W_wb_en;
        end else if (w_misalign) begin
          R_addr_err <= 1'b1;
          R_bad_addr <= W_alu_res;
        end else begin
          R_dreq     <= 1'b1;
          R_dwe      <= is_store(W_mem_op);
          R_daddr    <= {W_alu_res[31:2], 2'b00};
          R_dbe      <= byte_en(W_mem_op, W_alu_res[1:0]);
          R_dwdata   <= store_data(W_mem_op, W_wdata);
          r_op       <= W_mem_op;
          r_addr_lo  <= W_alu_res[1:0];
          r_pend_reg <= W_wb_reg;
          r_pend_en  <= W_wb_en;
        end
      end

      if (w_done) begin
        R_dreq     <= 1'b0;
        R_wb_valid <= 1'b1;
        R_wb_reg   <= r_pend_reg;
        if (is_store(r_op)) begin
          R_wb_en <= 1'b0;
        end else begin
          R_wb_en   <= r_pend_en;
          R_wb_data <= w_load_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for mem_access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;
  import mem_access_pkg::*;

  logic        W_clk = 1'b0;
  logic        W_rst;
  logic        W_valid;
  logic [31:0] W_alu_res;
  logic [31:0] W_wdata;
  logic [3:0]  W_mem_op;
  logic [4:0]  W_wb_reg;
  logic        W_wb_en;
  logic        W_dack;
  logic [31:0] W_drdata;
  logic        R_dreq, R_dwe, R_wb_valid, R_wb_en, R_stall, R_addr_err;
  logic [31:0] R_daddr, R_dwdata, R_wb_data, R_bad_addr;
  logic [3:0]  R_dbe;
  logic [4:0]  R_wb_reg;

  int n_vec = 0;
  int n_err = 0;

  mem_access dut (
    .W_clk(W_clk), .W_rst(W_rst), .W_valid(W_valid), .W_alu_res(W_alu_res),
    .W_wdata(W_wdata), .W_mem_op(W_mem_op), .W_wb_reg(W_wb_reg), .W_wb_en(W_wb_en),
    .R_dreq(R_dreq), .R_dwe(R_dwe), .R_daddr(R_daddr), .R_dbe(R_dbe),
    .R_dwdata(R_dwdata), .W_dack(W_dack), .W_drdata(W_drdata),
    .R_wb_valid(R_wb_valid), .R_wb_data(R_wb_data), .R_wb_reg(R_wb_reg),
    .R_wb_en(R_wb_en), .R_stall(R_stall), .R_addr_err(R_addr_err),
    .R_bad_addr(R_bad_addr)
  );

  always #5 W_clk = ~W_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge W_clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".dreq"},     R_dreq,     0);
    chk({tag, ".dwe"},      R_dwe,      0);
    chk({tag, ".daddr"},    R_daddr,    0);
    chk({tag, ".dbe"},      R_dbe,      0);
    chk({tag, ".dwdata"},   R_dwdata,   0);
    chk({tag, ".wb_valid"}, R_wb_valid, 0);
    chk({tag, ".wb_data"},  R_wb_data,  0);
    chk({tag, ".wb_reg"},   R_wb_reg,   0);
    chk({tag, ".wb_en"},    R_wb_en,    0);
    chk({tag, ".stall"},    R_stall,    0);
    chk({tag, ".addr_err"}, R_addr_err, 0);
    chk({tag, ".bad_addr"}, R_bad_addr, 0);
  endtask

  // Present one op for a single accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rg, input logic en);
    W_valid = 1'b1; W_mem_op = op; W_alu_res = addr;
    W_wdata = wd; W_wb_reg = rg; W_wb_en = en;
    step();
    W_valid = 1'b0;
  endtask

  // Issue a load/store, hold it BUSY for nbusy cycles, ack in the last one.
  // A NONE op is presented during BUSY and must be ignored.
  task automatic xfer(input string tag, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input int nbusy,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input logic [31:0] exp_data, input logic [4:0] rg);
    logic st;
    st = (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    issue(op, addr, wd, rg, 1'b1);
    W_valid = 1'b1; W_mem_op = MEM_NONE; W_alu_res = 32'h5555_AAAA;
    for (int i = 0; i < nbusy; i++) begin
      chk({tag, ".dreq"},     R_dreq,     1);
      chk({tag, ".stall"},    R_stall,    1);
      chk({tag, ".daddr"},    R_daddr,    {addr[31:2], 2'b00});
      chk({tag, ".dbe"},      R_dbe,      exp_be);
      chk({tag, ".dwe"},      R_dwe,      st);
      if (st) chk({tag, ".dwdata"}, R_dwdata, exp_wd);
      chk({tag, ".busy_wbv"}, R_wb_valid, 0);
      if (i == nbusy - 1) begin
        W_valid = 1'b0; W_dack = 1'b1; W_drdata = rd;
      end
      step();
    end
    W_dack = 1'b0; W_drdata = 32'h0;
    chk({tag, ".done_dreq"},  R_dreq,     0);
    chk({tag, ".done_stall"}, R_stall,    0);
    chk({tag, ".wb_valid"},   R_wb_valid, 1);
    chk({tag, ".wb_reg"},     R_wb_reg,   rg);
    chk({tag, ".wb_en"},      R_wb_en,    !st);
    if (!st) chk({tag, ".wb_data"}, R_wb_data, exp_data);
    step();
    chk({tag, ".wbv_pulse"},  R_wb_valid, 0);
  endtask

  initial begin
    W_rst = 1'b1; W_valid = 1'b0; W_alu_res = 0; W_wdata = 0; W_mem_op = MEM_NONE;
    W_wb_reg = 0; W_wb_en = 0; W_dack = 0; W_drdata = 0;
    step(); step();
    chk_zero("reset");
    W_rst = 1'b0;

    // Pass-through
    issue(MEM_NONE, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    chk("none.wb_valid", R_wb_valid, 1);
    chk("none.wb_data",  R_wb_data,  32'h0000_1234);
    chk("none.wb_reg",   R_wb_reg,   5);
    chk("none.wb_en",    R_wb_en,    1);
    chk("none.dreq",     R_dreq,     0);
    chk("none.stall",    R_stall,    0);
    step();
    chk("none.pulse",    R_wb_valid, 0);

    // Loads
    xfer("lb",   MEM_LB,  32'h0000_1003, 0, 32'h80FF_0000, 3, 4'hF, 0, 32'hFFFF_FF80, 5'd7);
    xfer("lbu",  MEM_LBU, 32'h0000_1003, 0, 32'h80FF_0000, 1, 4'hF, 0, 32'h0000_0080, 5'd8);
    xfer("lb2",  MEM_LB,  32'h0000_1002, 0, 32'h80FF_0000, 1, 4'hF, 0, 32'hFFFF_FFFF, 5'd9);
    xfer("lbu1", MEM_LBU, 32'h0000_1001, 0, 32'h1234_5678, 2, 4'hF, 0, 32'h0000_0056, 5'd9);
    xfer("lh",   MEM_LH,  32'h0000_1002, 0, 32'h80FF_0000, 1, 4'hF, 0, 32'hFFFF_80FF, 5'd10);
    xfer("lhu",  MEM_LHU, 32'h0000_1002, 0, 32'h80FF_0000, 1, 4'hF, 0, 32'h0000_80FF, 5'd11);
    xfer("lh0",  MEM_LH,  32'h0000_1000, 0, 32'h1234_7F00, 1, 4'hF, 0, 32'h0000_7F00, 5'd11);
    xfer("lw",   MEM_LW,  32'h0000_1004, 0, 32'h80FF_0000, 2, 4'hF, 0, 32'h80FF_0000, 5'd12);

    // Stores
    xfer("sh_hi", MEM_SH, 32'h0000_2002, 32'hDEAD_BEEF, 0, 2, 4'b1100, 32'hBEEF_BEEF, 0, 5'd3);
    xfer("sh_lo", MEM_SH, 32'h0000_2000, 32'hDEAD_BEEF, 0, 1, 4'b0011, 32'hBEEF_BEEF, 0, 5'd3);
    xfer("sb1",   MEM_SB, 32'h0000_3001, 32'h0000_00A5, 0, 1, 4'b0010, 32'hA5A5_A5A5, 0, 5'd4);
    xfer("sb3",   MEM_SB, 32'h0000_3003, 32'h0000_003C, 0, 1, 4'b1000, 32'h3C3C_3C3C, 0, 5'd4);
    xfer("sw",    MEM_SW, 32'h0000_4000, 32'hCAFE_F00D, 0, 1, 4'b1111, 32'hCAFE_F00D, 0, 5'd6);

    // Misaligned word load
    issue(MEM_LW, 32'h0000_0006, 0, 5'd2, 1'b1);
    chk("mis.dreq",     R_dreq,     0);
    chk("mis.addr_err", R_addr_err, 1);
    chk("mis.bad_addr", R_bad_addr, 32'h0000_0006);
    chk("mis.wb_valid", R_wb_valid, 0);
    chk("mis.stall",    R_stall,    0);
    step();
    chk("mis.pulse",    R_addr_err, 0);
    chk("mis.dreq2",    R_dreq,     0);

    // Misaligned halfword store
    issue(MEM_SH, 32'h0000_0101, 0, 5'd2, 1'b1);
    chk("mish.addr_err", R_addr_err, 1);
    chk("mish.bad_addr", R_bad_addr, 32'h0000_0101);
    chk("mish.dreq",     R_dreq,     0);

    // Ack while idle is ignored
    W_dack = 1'b1; W_drdata = 32'h1111_1111;
    step();
    W_dack = 1'b0;
    chk("idleack.wbv",   R_wb_valid, 0);
    chk("idleack.stall", R_stall,    0);

    // Reset in the second BUSY cycle, ack the cycle after
    issue(MEM_SW, 32'h0000_5000, 32'h1234_5678, 5'd9, 1'b1);
    chk("rst.busy1", R_stall, 1);
    step();
    chk("rst.busy2", R_stall, 1);
    W_rst = 1'b1;
    step();
    W_rst = 1'b0;
    chk_zero("rstbusy");
    W_dack = 1'b1;
    step();
    W_dack = 1'b0;
    chk("rst.ack_wbv",  R_wb_valid, 0);
    chk("rst.ack_dreq", R_dreq,     0);
    chk("rst.ack_stl",  R_stall,    0);

    // Back-to-back LW/LW, each acked in the first BUSY cycle
    issue(MEM_LW, 32'h0000_0010, 0, 5'd1, 1'b1);
    chk("b2b.dreq1",  R_dreq,  1);
    chk("b2b.daddr1", R_daddr, 32'h0000_0010);
    W_valid = 1'b1; W_mem_op = MEM_LW; W_alu_res = 32'h0000_0014; W_wb_reg = 5'd2;
    W_dack = 1'b1; W_drdata = 32'h1111_1111;
    step();
    W_dack = 1'b0;
    chk("b2b.wbv1",   R_wb_valid, 1);
    chk("b2b.data1",  R_wb_data,  32'h1111_1111);
    chk("b2b.reg1",   R_wb_reg,   1);
    chk("b2b.idle",   R_stall,    0);
    chk("b2b.nodreq", R_dreq,     0);
    step();
    W_valid = 1'b0;
    chk("b2b.dreq2",  R_dreq,     1);
    chk("b2b.daddr2", R_daddr,    32'h0000_0014);
    chk("b2b.wbv_lo", R_wb_valid, 0);
    W_dack = 1'b1; W_drdata = 32'h2222_2222;
    step();
    W_dack = 1'b0;
    chk("b2b.wbv2",   R_wb_valid, 1);
    chk("b2b.data2",  R_wb_data,  32'h2222_2222);
    chk("b2b.reg2",   R_wb_reg,   2);
    step();
    chk("b2b.end",    R_wb_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
